warp_ready_scoreboard: RTL
==========================

// Module: warp_ready_scoreboard
// PURPOSE
//  Per-warp readiness stage feeding the warp scheduler's ready_mask.
//  - Holds one decoded instruction per warp and a per-warp pending-write register scoreboard.
//  - Asserts ready_mask[w] when warp w's buffered instruction has no RAW/WAW hazard.
//  - Consumes the scheduler's one-hot grant and returns the granted instruction's operands.
// PARAMETERS
//  WARPS  8   number of warps (power of 2)
//  IDW    3   warp id width, log2(WARPS)
//  NREGS  32  architectural registers per warp (power of 2)
//  RW     5   register index width, log2(NREGS)
// PORTS
//  clk           in   1          clock, rising edge
//  rst_n         in   1          async active-low reset
//  fetch_valid   in   1          decoded instruction write into buffer
//  fetch_warp    in   IDW        target warp of fetch write
//  fetch_src1    in   RW         source register 1
//  fetch_src2    in   RW         source register 2
//  fetch_dst     in   RW         destination register
//  fetch_has_dst in   1          instruction writes fetch_dst
//  ibuf_free     out  WARPS      registered: buffer entry w empty
//  ready_mask    out  WARPS      to scheduler: warp w issuable
//  issue_onehot  in   WARPS      scheduler grant, at most one bit set
//  issue_fire    in   1          grant taken this cycle (scheduler issue_valid & issue_accept)
//  issue_src1    out  RW         src1 of granted warp (combinational mux)
//  issue_src2    out  RW         src2 of granted warp
//  issue_dst     out  RW         dst of granted warp
//  issue_has_dst out  1          has_dst of granted warp
//  wb_valid      in   1          writeback completes
//  wb_warp       in   IDW        writeback warp
//  wb_reg        in   RW         writeback register
//  warp_idle     out  WARPS      buffer empty and no pending writes for warp w
//  err_sticky    out  1          protocol violation seen; cleared only by reset
// BEHAVIOUR
//  Reset (async):
//  - All buffer valids and pending bits clear; err_sticky=0.
//  - Outputs: ibuf_free=all 1s, ready_mask=0, warp_idle=all 1s, issue_* = 0.
//  State per warp:
//  - Buffer: valid, src1, src2, dst, has_dst.
//  - Pending mask: pend[NREGS-1:0].
//  ready_mask:
//  - ready_mask[w] = valid & ~pend[src1] & ~pend[src2] & ~(has_dst & pend[dst]).
//  - Computed from registered state only; no same-cycle bypass of wb or issue.
//  - A wb clear in cycle N makes the warp ready in cycle N+1.
//  issue_* outputs:
//  - AND-OR mux of buffer fields selected by issue_onehot.
//  - All zero when issue_onehot==0.
//  Issue (issue_fire & issue_onehot[w]), at the next edge:
//  - Clears valid[w].
//  - If has_dst, sets pend[w][dst].
//  Fetch write:
//  - Accepted if valid[fetch_warp]==0, or that warp issues in the same cycle (refill).
//  - Accepted entry loads at the next edge with valid=1.
//  - Otherwise dropped, buffer unchanged, err_sticky<=1.
//  Writeback:
//  - Clears pend[wb_warp][wb_reg] at the next edge.
//  - wb to a non-pending register sets err_sticky; state unchanged.
//  Simultaneous events:
//  - Issue setting bit (w,r) and wb clearing (w,r) in the same cycle: set wins, bit stays 1.
//  - Distinct bits update independently.
//  Errors:
//  - issue_fire with a onehot bit on an invalid entry: no state change, err_sticky<=1.
//  - issue_fire with more than one onehot bit: no state change, err_sticky<=1.
//  warp_idle[w] = ~valid[w] & (pend[w]==0), from registered state.
//  Reset mid-operation discards all buffered instructions and pending bits immediately.
// TESTING
//  1. Reset -> ready_mask=0, ibuf_free=8'hFF, warp_idle=8'hFF, err_sticky=0.
//  2. Fetch w2 src1=3 src2=4 dst=5 -> next cycle ready_mask=8'h04, ibuf_free=8'hFB;
//     fire onehot 8'h04 -> issue_dst=5; next cycle ready_mask=0, pend[2][5]=1.
//  3. RAW: w2 dst=5 pending, fetch w2 src1=5 -> ready_mask[2]=0;
//     wb w2 r5 at cycle N -> ready_mask[2]=1 at N+1.
//  4. Same cycle: fire w1 (dst=7) and wb w1 r7 (pending from earlier) -> pend[1][7] stays 1.
//  5. Same cycle: fire w0 and fetch w0 -> new entry valid next cycle, err_sticky=0;
//     fetch w3 while occupied -> dropped, err_sticky=1.
//  6. Mid-operation: all 8 warps full with pending regs, assert rst_n=0 ->
//     outputs return to reset values asynchronously.

Source files
------------

// File: rtl/warp_ready_scoreboard_if.sv
// Bundle between the warp scheduler side and the readiness scoreboard.
//   master : drives fetch writes, the issue grant and writebacks; observes status.
//   slave  : the scoreboard; returns free/ready/idle masks, the granted
//            instruction's operands and the sticky protocol error.
interface warp_ready_scoreboard_if #(
  parameter int WARPS = 8,
  parameter int IDW   = 3,
  parameter int NREGS = 32,
  parameter int RW    = 5
);
  logic             fetch_valid;
  logic [IDW-1:0]   fetch_warp;
  logic [RW-1:0]    fetch_src1;
  logic [RW-1:0]    fetch_src2;
  logic [RW-1:0]    fetch_dst;
  logic             fetch_has_dst;
  logic [WARPS-1:0] ibuf_free;
  logic [WARPS-1:0] ready_mask;
  logic [WARPS-1:0] issue_onehot;
  logic             issue_fire;
  logic [RW-1:0]    issue_src1;
  logic [RW-1:0]    issue_src2;
  logic [RW-1:0]    issue_dst;
  logic             issue_has_dst;
  logic             wb_valid;
  logic [IDW-1:0]   wb_warp;
  logic [RW-1:0]    wb_reg;
  logic [WARPS-1:0] warp_idle;
  logic             err_sticky;

  modport master (
    output fetch_valid, fetch_warp, fetch_src1, fetch_src2, fetch_dst, fetch_has_dst,
    output issue_onehot, issue_fire, wb_valid, wb_warp, wb_reg,
    input  ibuf_free, ready_mask, issue_src1, issue_src2, issue_dst, issue_has_dst,
    input  warp_idle, err_sticky
  );

  modport slave (
    input  fetch_valid, fetch_warp, fetch_src1, fetch_src2, fetch_dst, fetch_has_dst,
    input  issue_onehot, issue_fire, wb_valid, wb_warp, wb_reg,
    output ibuf_free, ready_mask, issue_src1, issue_src2, issue_dst, issue_has_dst,
    output warp_idle, err_sticky
  );
endinterface

// File: rtl/warp_ready_scoreboard.sv
// Per-warp readiness stage for the warp scheduler.
//   warp_slot            : one warp's instruction buffer entry + pending-write mask.
//   warp_ready_scoreboard: array of slots, grant/fetch/writeback arbitration,
//                          issue operand mux and sticky protocol error.
// Ports: clk, rst_n (async active low), bus (warp_ready_scoreboard_if.slave).
module warp_slot #(
  parameter int NREGS = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             load,
  input  logic [RW-1:0]    ld_src1,
  input  logic [RW-1:0]    ld_src2,
  input  logic [RW-1:0]    ld_dst,
  input  logic             ld_has_dst,
  input  logic             wb_clr,
  input  logic [RW-1:0]    wb_reg,
  output logic             valid,
  output logic [RW-1:0]    src1,
  output logic [RW-1:0]    src2,
  output logic [RW-1:0]    dst,
  output logic             has_dst,
  output logic [NREGS-1:0] pend,
  output logic             ready
);
  logic [NREGS-1:0] set_mask, clr_mask;

  assign set_mask = (issue & has_dst) ? (NREGS'(1) << dst) : '0;
  assign clr_mask = wb_clr ? (NREGS'(1) << wb_reg) : '0;
  assign ready    = valid & ~pend[src1] & ~pend[src2] & ~(has_dst & pend[dst]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      src1    <= '0;
      src2    <= '0;
      dst     <= '0;
      has_dst <= 1'b0;
      pend    <= '0;
    end else begin
      // load wins over issue so a same-cycle refill leaves the entry valid
      if (load) begin
        valid   <= 1'b1;
        src1    <= ld_src1;
        src2    <= ld_src2;
        dst     <= ld_dst;
        has_dst <= ld_has_dst;
      end else if (issue) begin
        valid   <= 1'b0;
      end
      // set applied after clear: issue marking a reg beats its own writeback
      pend <= (pend & ~clr_mask) | set_mask;
    end
  end
endmodule

module warp_ready_scoreboard #(
  parameter int WARPS = 8,
  parameter int IDW   = 3,
  parameter int NREGS = 32,
  parameter int RW    = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  warp_ready_scoreboard_if.slave bus
);
  logic [WARPS-1:0]            valid, has_dst, ready, iss, load, wb_clr;
  logic [WARPS-1:0][RW-1:0]    src1, src2, dst;
  logic [WARPS-1:0][NREGS-1:0] pend;
  logic multi, bad_inv, fire_ok, fetch_drop, wb_bad, err;

  // Grant is honoured only if exactly one bit is set and it hits a valid entry.
  assign multi      = |(bus.issue_onehot & (bus.issue_onehot - WARPS'(1)));
  assign bad_inv    = |(bus.issue_onehot & ~valid);
  assign fire_ok    = bus.issue_fire & ~multi & ~bad_inv;
  assign iss        = fire_ok ? bus.issue_onehot : '0;
  assign fetch_drop = bus.fetch_valid & valid[bus.fetch_warp] & ~iss[bus.fetch_warp];
  assign wb_bad     = bus.wb_valid & ~pend[bus.wb_warp][bus.wb_reg];

  for (genvar w = 0; w < WARPS; w++) begin : g_warp
    assign load[w]   = bus.fetch_valid & (bus.fetch_warp == IDW'(w)) & (~valid[w] | iss[w]);
    assign wb_clr[w] = bus.wb_valid & (bus.wb_warp == IDW'(w)) & pend[w][bus.wb_reg];

    warp_slot #(.NREGS(NREGS), .RW(RW)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue      (iss[w]),
      .load       (load[w]),
      .ld_src1    (bus.fetch_src1),
      .ld_src2    (bus.fetch_src2),
      .ld_dst     (bus.fetch_dst),
      .ld_has_dst (bus.fetch_has_dst),
      .wb_clr     (wb_clr[w]),
      .wb_reg     (bus.wb_reg),
      .valid      (valid[w]),
      .src1       (src1[w]),
      .src2       (src2[w]),
      .dst        (dst[w]),
      .has_dst    (has_dst[w]),
      .pend       (pend[w]),
      .ready      (ready[w])
    );

    assign bus.warp_idle[w] = ~valid[w] & ~|pend[w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if ((bus.issue_fire & (multi | bad_inv)) | fetch_drop | wb_bad) err <= 1'b1;
  end

  // AND-OR operand mux; zero when no grant bit is set
  always_comb begin
    bus.issue_src1    = '0;
    bus.issue_src2    = '0;
    bus.issue_dst     = '0;
    bus.issue_has_dst = 1'b0;
    for (int w = 0; w < WARPS; w++) begin
      bus.issue_src1    = bus.issue_src1 | (src1[w] & {RW{bus.issue_onehot[w]}});
      bus.issue_src2    = bus.issue_src2 | (src2[w] & {RW{bus.issue_onehot[w]}});
      bus.issue_dst     = bus.issue_dst  | (dst[w]  & {RW{bus.issue_onehot[w]}});
      bus.issue_has_dst = bus.issue_has_dst | (has_dst[w] & bus.issue_onehot[w]);
    end
  end

  assign bus.ibuf_free  = ~valid;
  assign bus.ready_mask = ready;
  assign bus.err_sticky = err;
endmodule
